// File: rtl/cpu_pkg.sv
// Shared opcodes, phase numbers and strobe bundle
// for the 8-phase accumulator CPU sequencer.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int PHASE_WIDTH  = 3;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [PHASE_WIDTH-1:0]  phase_t;

    localparam opcode_t OP_HLT = 3'd0;
    localparam opcode_t OP_SKZ = 3'd1;
    localparam opcode_t OP_ADD = 3'd2;
    localparam opcode_t OP_AND = 3'd3;
    localparam opcode_t OP_XOR = 3'd4;
    localparam opcode_t OP_LDA = 3'd5;
    localparam opcode_t OP_STO = 3'd6;
    localparam opcode_t OP_JMP = 3'd7;

    localparam phase_t PH_INST_ADDR  = 3'd0;
    localparam phase_t PH_INST_FETCH = 3'd1;
    localparam phase_t PH_INST_LOAD  = 3'd2;
    localparam phase_t PH_IDLE       = 3'd3;
    localparam phase_t PH_OP_ADDR    = 3'd4;
    localparam phase_t PH_OP_FETCH   = 3'd5;
    localparam phase_t PH_ALU_OP     = 3'd6;
    localparam phase_t PH_STORE      = 3'd7;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic halt;
        logic inc_pc;
        logic ld_ac;
        logic ld_pc;
        logic wr;
        logic data_e;
    } strobes_t;

    // Opcodes that read an operand from memory into the ALU.
    function automatic logic is_aluop(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) ||
               (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Sequencer bus: IR/ALU status in, datapath strobes
// and debug state out.
interface cpu_controller_if;
    import cpu_pkg::*;

    opcode_t opcode;
    logic    zero;
    logic    mem_ready;
    logic    sel;
    logic    rd;
    logic    ld_ir;
    logic    halt;
    logic    inc_pc;
    logic    ld_ac;
    logic    ld_pc;
    logic    wr;
    logic    data_e;
    phase_t  phase;
    logic    halted;

    modport master (
        input  opcode, zero, mem_ready,
        output sel, rd, ld_ir, halt, inc_pc,
        output ld_ac, ld_pc, wr, data_e,
        output phase, halted
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  sel, rd, ld_ir, halt, inc_pc,
        input  ld_ac, ld_pc, wr, data_e,
        input  phase, halted
    );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decode from the current phase,
// halted flag, opcode and zero flag.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  phase_t   phase_i,
    input  logic     halted_i,
    input  opcode_t  opcode_i,
    input  logic     zero_i,
    output strobes_t strb_o
);

    logic alu;
    logic sto;
    logic jmp;

    assign alu = is_aluop(opcode_i);
    assign sto = (opcode_i == OP_STO);
    assign jmp = (opcode_i == OP_JMP);

    // Halted overrides everything; otherwise decode per phase.
    always_comb begin
        strb_o = '0;
        if (halted_i) begin
            strb_o.halt = 1'b1;
        end else begin
            unique case (phase_i)
                PH_INST_ADDR: begin
                    strb_o.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    strb_o.sel = 1'b1;
                    strb_o.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    strb_o.sel   = 1'b1;
                    strb_o.rd    = 1'b1;
                    strb_o.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    strb_o.inc_pc = 1'b1;
                    strb_o.halt   = (opcode_i == OP_HLT);
                end
                PH_OP_FETCH: begin
                    strb_o.rd = alu;
                end
                PH_ALU_OP: begin
                    strb_o.rd     = alu;
                    strb_o.inc_pc = (opcode_i == OP_SKZ) && zero_i;
                    strb_o.ld_pc  = jmp;
                    strb_o.data_e = sto;
                end
                PH_STORE: begin
                    strb_o.rd     = alu;
                    strb_o.ld_ac  = alu;
                    strb_o.ld_pc  = jmp;
                    strb_o.wr     = sto;
                    strb_o.data_e = sto;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer: phase counter, sticky
// halt and memory-ready stall around the strobe decoder.
module cpu_controller
    import cpu_pkg::*;
(
    input logic clk,
    input logic rst_n,
    cpu_controller_if.master bus
);

    phase_t   phase_q;
    phase_t   phase_d;
    logic     halted_q;
    logic     halted_d;
    logic     stall;
    strobes_t strb;

    cpu_ctrl_decode u_decode (
        .phase_i  (phase_q),
        .halted_i (halted_q),
        .opcode_i (bus.opcode),
        .zero_i   (bus.zero),
        .strb_o   (strb)
    );

    // Operand fetch only waits when it actually reads memory.
    assign stall = !bus.mem_ready &&
                   ((phase_q == PH_INST_FETCH) ||
                    (phase_q == PH_OP_FETCH && strb.rd));

    // Next phase: freeze when halted or halting, hold on stall.
    always_comb begin
        phase_d  = phase_q + phase_t'(1);
        halted_d = halted_q;
        if (halted_q) begin
            phase_d = phase_q;
        end else if (phase_q == PH_OP_ADDR && bus.opcode == OP_HLT) begin
            halted_d = 1'b1;
            phase_d  = phase_q;
        end else if (stall) begin
            phase_d = phase_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign bus.sel    = strb.sel;
    assign bus.rd     = strb.rd;
    assign bus.ld_ir  = strb.ld_ir;
    assign bus.halt   = strb.halt;
    assign bus.inc_pc = strb.inc_pc;
    assign bus.ld_ac  = strb.ld_ac;
    assign bus.ld_pc  = strb.ld_pc;
    assign bus.wr     = strb.wr;
    assign bus.data_e = strb.data_e;
    assign bus.phase  = phase_q;
    assign bus.halted = halted_q;

endmodule
